// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
// Holds the FSM state encoding, address-split widths and default geometry.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MISS       = 3'd1,
        ST_WRITEBACK  = 3'd2,
        ST_READMISS   = 3'd3,
        ST_READMISSOK = 3'd4
    } dc_state_e;

    localparam int OFFSET_W     = 5;
    localparam int WSEL_W       = 3;
    localparam int WORD_W       = 32;
    localparam int DEF_NLINES   = 32;
    localparam int DEF_BLK_BITS = 256;

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: valid/dirty bits, tags and data blocks.
// Reads are combinational; one synchronous write port updates a whole line.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NLINES   = DEF_NLINES,
    parameter int BLK_BITS = DEF_BLK_BITS,
    parameter int IDX_W    = 5,
    parameter int TAG_W    = 22
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_W-1:0]    idx,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLK_BITS-1:0] rd_data,
    input  logic                wr_en,
    input  logic                wr_valid,
    input  logic                wr_dirty,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLK_BITS-1:0] wr_data
);

    logic [NLINES-1:0]   valid_r;
    logic [NLINES-1:0]   dirty_r;
    logic [TAG_W-1:0]    tag_r  [NLINES];
    logic [BLK_BITS-1:0] data_r [NLINES];

    assign rd_valid = valid_r[idx];
    assign rd_dirty = dirty_r[idx];
    assign rd_tag   = tag_r[idx];
    assign rd_data  = data_r[idx];

    // Line status bits; cleared by reset so every line starts invalid and clean.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (wr_en) begin
            valid_r[idx] <= wr_valid;
            dirty_r[idx] <= wr_dirty;
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid_r.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_r[idx]  <= wr_tag;
            data_r[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hit detection and the miss FSM live here; line storage is in dcache_sram.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NLINES   = DEF_NLINES,
    parameter int BLK_BITS = DEF_BLK_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         p1_addr_i,
    input  logic [31:0]         p1_data_i,
    input  logic                p1_MemRead_i,
    input  logic                p1_MemWrite_i,
    output logic [31:0]         p1_data_o,
    output logic                p1_stall_o,
    input  logic [BLK_BITS-1:0] mem_data_i,
    input  logic                mem_ack_i,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [31:0]         mem_addr_o,
    output logic [BLK_BITS-1:0] mem_data_o
);

    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    dc_state_e            state_r;
    dc_state_e            state_nx_s;
    logic [IDX_W-1:0]     idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [WSEL_W-1:0]    wsel_s;
    logic                 req_s;
    logic                 hit_s;
    logic                 line_valid_s;
    logic                 line_dirty_s;
    logic [TAG_W-1:0]     line_tag_s;
    logic [BLK_BITS-1:0]  line_data_s;
    logic                 wr_en_s;
    logic                 wr_valid_s;
    logic                 wr_dirty_s;
    logic [BLK_BITS-1:0]  wr_data_s;
    logic                 unused_ok_s;

    assign idx_s       = p1_addr_i[OFFSET_W +: IDX_W];
    assign tag_s       = p1_addr_i[31 -: TAG_W];
    assign wsel_s      = p1_addr_i[OFFSET_W-1:2];
    assign unused_ok_s = ^p1_addr_i[1:0];

    assign req_s = p1_MemRead_i | p1_MemWrite_i;
    assign hit_s = req_s & line_valid_s & (line_tag_s == tag_s);

    dcache_sram #(
        .NLINES   (NLINES),
        .BLK_BITS (BLK_BITS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .idx      (idx_s),
        .rd_valid (line_valid_s),
        .rd_dirty (line_dirty_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s),
        .wr_en    (wr_en_s),
        .wr_valid (wr_valid_s),
        .wr_dirty (wr_dirty_s),
        .wr_tag   (tag_s),
        .wr_data  (wr_data_s)
    );

    // Line update: store on a write hit (MemRead+MemWrite counts as a store), refill on ack.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_valid_s = 1'b0;
        wr_dirty_s = 1'b0;
        wr_data_s  = line_data_s;
        if ((state_r == ST_IDLE) && hit_s && p1_MemWrite_i) begin
            wr_en_s    = 1'b1;
            wr_valid_s = 1'b1;
            wr_dirty_s = 1'b1;
            wr_data_s[int'(wsel_s)*WORD_W +: WORD_W] = p1_data_i;
        end else if ((state_r == ST_READMISS) && mem_ack_i) begin
            wr_en_s    = 1'b1;
            wr_valid_s = 1'b1;
            wr_dirty_s = 1'b0;
            wr_data_s  = mem_data_i;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Pipeline-facing outputs: same-cycle load data and freeze request.
    always_comb begin
        p1_data_o  = 32'd0;
        p1_stall_o = 1'b0;
        if (hit_s) begin
            p1_data_o = line_data_s[int'(wsel_s)*WORD_W +: WORD_W];
        end else begin
            p1_data_o = 32'd0;
        end
        if ((req_s && !hit_s) || (state_r != ST_IDLE)) begin
            p1_stall_o = 1'b1;
        end else begin
            p1_stall_o = 1'b0;
        end
    end

    // Miss FSM state register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Miss FSM next state and memory-side outputs; mem_ack_i only matters while a request is up.
    always_comb begin
        state_nx_s   = state_r;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !hit_s) begin
                    state_nx_s = ST_MISS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MISS: begin
                if (line_valid_s && line_dirty_s) begin
                    state_nx_s = ST_WRITEBACK;
                end else begin
                    state_nx_s = ST_READMISS;
                end
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag_s, idx_s, 5'b00000};
                mem_data_o   = line_data_s;
                if (mem_ack_i) begin
                    state_nx_s = ST_READMISS;
                end else begin
                    state_nx_s = ST_WRITEBACK;
                end
            end
            ST_READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag_s, idx_s, 5'b00000};
                if (mem_ack_i) begin
                    state_nx_s = ST_READMISSOK;
                end else begin
                    state_nx_s = ST_READMISS;
                end
            end
            ST_READMISSOK: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses push expected memory
// transactions and load words; a negedge monitor pops and compares them.
module tb_dcache_ctrl;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] blk;
    } mem_exp_t;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;

    mem_exp_t     exp_mem[$];
    logic [31:0]  exp_load[$];
    int           n_vec;
    int           n_err;
    logic         auto_ack;

    dcache_ctrl #(.NLINES(32), .BLK_BITS(256)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory image: word w of the block at aligned address a is 0x10000000 | a | w.
    function automatic logic [255:0] mk_blk(input logic [31:0] a);
        logic [255:0] b;
        b = '0;
        for (int w = 0; w < 8; w++) begin
            b[w*32 +: 32] = 32'h1000_0000 | a | 32'(w);
        end
        return b;
    endfunction

    function automatic logic [255:0] put_word(input logic [255:0] b, input int w, input logic [31:0] d);
        logic [255:0] r;
        r = b;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks 3 cycles into any request while auto_ack is set.
    initial begin
        int lat;
        lat = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #2;
            if (auto_ack) begin
                mem_ack_i = 1'b0;
                if (mem_enable_o && rst_i) begin
                    if (lat == 2) begin
                        mem_ack_i  = 1'b1;
                        mem_data_i = mk_blk(mem_addr_o);
                        lat = 0;
                    end else begin
                        lat++;
                    end
                end else begin
                    lat = 0;
                end
            end
        end
    end

    // Monitor: checks each new memory transaction, each completed load, and the refill tail timing.
    initial begin
        logic prev_en, prev_wr;
        int rok;
        mem_exp_t e;
        prev_en = 1'b0;
        prev_wr = 1'b0;
        rok = 0;
        forever begin
            @(negedge clk_i);
            if (rok == 1) begin
                chk("readmissok_stall", p1_stall_o, 1'b1);
                chk("readmissok_enable", mem_enable_o, 1'b0);
                rok = 2;
            end else if (rok == 2) begin
                chk("stall_drop_after_readmissok", p1_stall_o, 1'b0);
                rok = 0;
            end
            if (mem_enable_o && (!prev_en || (prev_wr != mem_write_o))) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_txn", mem_addr_o, 32'hFFFF_FFFF);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_write", mem_write_o, e.wr);
                    chk("mem_addr", mem_addr_o, e.addr);
                    if (e.wr) chk("wb_block", mem_data_o, e.blk);
                end
            end
            if (rst_i && mem_ack_i && mem_enable_o && !mem_write_o) rok = 1;
            if (rst_i && p1_MemRead_i && !p1_MemWrite_i && !p1_stall_o) begin
                if (exp_load.size() == 0) begin
                    chk("unexpected_load", p1_data_o, 32'hFFFF_FFFF);
                end else begin
                    chk("load_data", p1_data_o, exp_load.pop_front());
                end
            end
            prev_en = mem_enable_o;
            prev_wr = mem_write_o;
        end
    end

    // One pipeline access: hold it until the cache stops stalling, then let it complete.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, input logic exp_stall);
        int cyc;
        @(posedge clk_i); #2;
        p1_addr_i     = a;
        p1_data_i     = d;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        #1;
        chk("stall_first_cycle", p1_stall_o, exp_stall);
        cyc = 0;
        while (p1_stall_o && cyc < 100) begin
            @(posedge clk_i); #2;
            cyc++;
        end
        if (cyc >= 100) chk("stall_timeout", 1'b1, 1'b0);
        @(posedge clk_i); #2;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;
        auto_ack      = 1'b1;
        rst_i         = 1'b0;
        p1_addr_i     = 32'd0;
        p1_data_i     = 32'd0;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_stall", p1_stall_o, 1'b0);
        chk("rst_enable", mem_enable_o, 1'b0);
        chk("rst_write", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'd0);
        @(posedge clk_i); #2;
        rst_i = 1'b1;

        exp_mem.push_back('{1'b0, 32'h0000_0040, '0});
        exp_load.push_back(32'h1000_0040);
        access(32'h0000_0040, 32'd0, 1'b1, 1'b0, 1'b1);
        exp_load.push_back(32'h1000_0043);
        access(32'h0000_004C, 32'd0, 1'b1, 1'b0, 1'b0);
        access(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        exp_load.push_back(32'hDEAD_BEEF);
        access(32'h0000_0040, 32'd0, 1'b1, 1'b0, 1'b0);

        exp_mem.push_back('{1'b1, 32'h0000_0040, put_word(mk_blk(32'h40), 0, 32'hDEAD_BEEF)});
        exp_mem.push_back('{1'b0, 32'h0000_0840, '0});
        exp_load.push_back(32'h1000_0840);
        access(32'h0000_0840, 32'd0, 1'b1, 1'b0, 1'b1);

        exp_mem.push_back('{1'b0, 32'h0000_1040, '0});
        exp_load.push_back(32'h1000_1040);
        access(32'h0000_1040, 32'd0, 1'b1, 1'b0, 1'b1);

        exp_mem.push_back('{1'b0, 32'h0000_03E0, '0});
        exp_load.push_back(32'h1000_03E0);
        access(32'h0000_03E0, 32'd0, 1'b1, 1'b0, 1'b1);
        exp_load.push_back(32'h1000_03E7);
        access(32'h0000_03FC, 32'd0, 1'b1, 1'b0, 1'b0);
        access(32'h0000_03E4, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        exp_load.push_back(32'h1234_5678);
        access(32'h0000_03E4, 32'd0, 1'b1, 1'b0, 1'b0);
        exp_mem.push_back('{1'b1, 32'h0000_03E0, put_word(mk_blk(32'h3E0), 1, 32'h1234_5678)});
        exp_mem.push_back('{1'b0, 32'h0000_07E0, '0});
        exp_load.push_back(32'h1000_07E0);
        access(32'h0000_07E0, 32'd0, 1'b1, 1'b0, 1'b1);

        exp_mem.push_back('{1'b0, 32'h0000_0000, '0});
        exp_load.push_back(32'h1000_0000);
        access(32'h0000_0000, 32'd0, 1'b1, 1'b0, 1'b1);
        exp_load.push_back(32'h1000_0007);
        access(32'h0000_001C, 32'd0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a refill, with a stray ack arriving afterwards.
        auto_ack = 1'b0;
        exp_mem.push_back('{1'b0, 32'h0000_2040, '0});
        @(posedge clk_i); #2;
        p1_addr_i    = 32'h0000_2040;
        p1_MemRead_i = 1'b1;
        cyc = 0;
        while (!(mem_enable_o && !mem_write_o) && cyc < 20) begin
            @(posedge clk_i); #2;
            cyc++;
        end
        chk("reach_readmiss", cyc < 20, 1'b1);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        chk("abort_enable", mem_enable_o, 1'b0);
        chk("abort_stall_req_held", p1_stall_o, 1'b1);
        p1_MemRead_i = 1'b0;
        #1;
        chk("abort_stall_idle", p1_stall_o, 1'b0);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        @(posedge clk_i); #2;
        mem_data_i = mk_blk(32'h0000_2040);
        mem_ack_i  = 1'b1;
        @(posedge clk_i); #2;
        mem_ack_i = 1'b0;
        chk("late_ack_enable", mem_enable_o, 1'b0);
        chk("late_ack_stall", p1_stall_o, 1'b0);
        auto_ack = 1'b1;
        exp_mem.push_back('{1'b0, 32'h0000_2040, '0});
        exp_load.push_back(32'h1000_2040);
        access(32'h0000_2040, 32'd0, 1'b1, 1'b0, 1'b1);
        exp_mem.push_back('{1'b0, 32'h0000_03E0, '0});
        exp_load.push_back(32'h1000_03E0);
        access(32'h0000_03E0, 32'd0, 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk_i);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        chk("load_queue_drained", 32'(exp_load.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
